uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmit FIFO (fifo_spram feeding uart) between NumReq byte-stream requesters, such as CPU CSR writes, a debug monitor and a test-pattern generator.
Grants are packet-locked: a requester keeps the FIFO write port until it presents its last byte or hits the MaxBurst fairness cap.
Sits directly in front of the FIFO write port and replaces ad-hoc write-enable generation.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 95 +++++++++
 tb/tb_uart_tx_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams and the FIFO write port shared by uart_tx_arbiter.
// master drives requests and FIFO status; slave is the arbiter.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
    parameter int unsigned NumReq = 4
);
    localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0]       req_valid;
    logic [NumReq-1:0][7:0]  req_data;
    logic [NumReq-1:0]       req_last;
    logic [NumReq-1:0]       req_ready;
    logic                    fifo_full;
    logic                    fifo_we;
    logic [7:0]              fifo_data;
    logic [IdW-1:0]          grant_id;
    logic                    busy;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_we, fifo_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_we, fifo_data, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of the UART TX FIFO write port.
// A grant lasts until the requester's last byte or MaxBurst bytes, then rotates.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned MaxBurst = 16
) (
    input logic               clk_i,
    input logic               reset_i,
    uart_tx_arbiter_if.slave  bus
);
    localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;
    localparam logic [CntW-1:0] BurstLast = CntW'((MaxBurst > 0) ? MaxBurst - 1 : 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]  grant_q, grant_d;
    logic [CntW-1:0] burst_q, burst_d;

    logic            found;
    logic [IdW-1:0]  pick;
    logic [IdW-1:0]  cand;
    int unsigned     idx;
    logic            handshake;

    // First valid requester scanning upward from rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx  = (32'(rr_ptr_q) + k) % NumReq;
            cand = IdW'(idx);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        burst_d       = burst_q;
        handshake     = 1'b0;
        bus.req_ready = '0;
        bus.fifo_we   = 1'b0;
        bus.fifo_data = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    burst_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                bus.req_ready[grant_q] = !bus.fifo_full;
                handshake              = bus.req_valid[grant_q] && !bus.fifo_full;
                bus.fifo_we            = handshake;
                if (handshake) begin
                    bus.fifo_data = bus.req_data[grant_q];
                    burst_d       = burst_q + 1'b1;
                    if (bus.req_last[grant_q] || (MaxBurst != 0 && burst_q == BurstLast)) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == IdW'(NumReq - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            burst_q  <= burst_d;
        end
    end

    assign bus.grant_id = grant_q;
    assign bus.busy     = (state_q == GRANT);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester packet queues, a packet-level
// round-robin model predicting the FIFO write stream, and cycle-level checks.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned MB = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NumReq(NR)) bus ();
    uart_tx_arbiter #(.NumReq(NR), .MaxBurst(MB)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [8:0]  rq [NR][$];   // {last, data} per requester
    logic [9:0]  exq [$];      // {id, data} expected FIFO writes in order
    int unsigned m_ptr = 0;
    int          m_total = 0;  // expected cycles with no stalls
    int          last_wr;
    int          writes;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Packet-level model: pick the first non-empty requester from m_ptr,
    // take bytes until last or MB bytes, rotate past it.
    task automatic build_expected();
        int unsigned pos [NR];
        int unsigned g, n;
        bit          any;
        logic [8:0]  b;
        foreach (pos[i]) pos[i] = 0;
        m_total = 0;
        forever begin
            any = 0;
            g   = 0;
            for (int unsigned k = 0; k < NR; k++) begin
                int unsigned c = (m_ptr + k) % NR;
                if (!any && pos[c] < rq[c].size()) begin
                    any = 1;
                    g   = c;
                end
            end
            if (!any) break;
            n = 0;
            do begin
                b = rq[g][pos[g]];
                pos[g]++;
                n++;
                exq.push_back({g[1:0], b[7:0]});
            end while (!b[8] && n != MB && pos[g] < rq[g].size());
            m_total += int'(n) + 1;
            m_ptr = (g + 1) % NR;
        end
    endtask

    task automatic drive(input bit full);
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i] = rq[i].size() > 0;
            if (rq[i].size() > 0) begin
                bus.req_data[i] = rq[i][0][7:0];
                bus.req_last[i] = rq[i][0][8];
            end else begin
                bus.req_data[i] = 8'($urandom);
                bus.req_last[i] = 1'($urandom_range(0, 1));
            end
        end
        bus.fifo_full = full;
    endtask

    task automatic sample(input int cyc, input int st_lo, input int st_hi);
        logic [NR-1:0] exp_ready;
        logic [1:0]    eid;
        bit            exp_we;
        exp_ready = '0;
        exp_we    = 0;
        eid       = (exq.size() > 0) ? exq[0][9:8] : 2'd0;
        if (cyc == 0) check_eq("busy_arb", bus.busy, 0);
        if (cyc >= st_lo && cyc <= st_hi) check_eq("busy_stall", bus.busy, 1);
        if (bus.busy) begin
            check_eq("grant_id", bus.grant_id, eid);
            if (!bus.fifo_full) exp_ready[eid] = 1'b1;
            exp_we = !bus.fifo_full && bus.req_valid[eid];
        end
        check_eq("req_ready", bus.req_ready, exp_ready);
        check_eq("fifo_we", bus.fifo_we, exp_we);
        if (bus.fifo_we) begin
            if (exq.size() == 0) begin
                check_eq("spurious_we", bus.fifo_we, 0);
            end else begin
                check_eq("fifo_data", bus.fifo_data, exq[0][7:0]);
                void'(exq.pop_front());
            end
            last_wr = cyc;
            writes++;
        end else begin
            check_eq("data_idle", bus.fifo_data, 0);
        end
        for (int i = 0; i < NR; i++)
            if (bus.req_valid[i] && bus.req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    endtask

    // extra < 0 skips the throughput check; otherwise it is the stall cycles expected.
    task automatic run_phase(input string name, input int extra, input int st_lo, input int st_hi,
                             input bit rnd_full, input int abort_after);
        int cyc;
        bit pending;
        build_expected();
        cyc     = 0;
        writes  = 0;
        last_wr = -1;
        forever begin
            pending = 0;
            foreach (rq[i]) if (rq[i].size() > 0) pending = 1;
            if (!pending || cyc >= 3000 || (abort_after > 0 && writes >= abort_after)) break;
            drive((cyc >= st_lo && cyc <= st_hi) || (rnd_full && $urandom_range(0, 3) == 0));
            #1;
            sample(cyc, st_lo, st_hi);
            @(posedge clk);
            #1;
            cyc++;
        end
        if (abort_after == 0) begin
            check_eq({name, "_no_timeout"}, 32'(cyc < 3000), 1);
            check_eq({name, "_drained"}, exq.size(), 0);
            if (extra >= 0) check_eq({name, "_last_cycle"}, last_wr, m_total - 1 + extra);
            drive(0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_we"}, bus.fifo_we, 0);
        check_eq({tag, "_ready"}, bus.req_ready, 0);
        check_eq({tag, "_data"}, bus.fifo_data, 0);
        check_eq({tag, "_gid"}, bus.grant_id, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(0);
        #12;
        check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Single 4-byte packet from req0.
        rq[0].push_back(9'h0DE); rq[0].push_back(9'h0AD);
        rq[0].push_back(9'h0BE); rq[0].push_back(9'h1EF);
        run_phase("t1", 0, -1, -1, 0, 0);
        check_eq("t1_gid_hold", bus.grant_id, 0);

        // rr_ptr now 1: req1 must beat req0.
        rq[0].push_back(9'h111); rq[1].push_back(9'h122);
        run_phase("t1_ptr", 0, -1, -1, 0, 0);

        // Two 2-byte packets arriving together, no interleaving.
        rq[1].push_back(9'h031); rq[1].push_back(9'h132);
        rq[2].push_back(9'h041); rq[2].push_back(9'h142);
        run_phase("t2", 0, -1, -1, 0, 0);

        // Stall for 3 cycles after byte 2.
        rq[2].push_back(9'h051); rq[2].push_back(9'h052);
        rq[2].push_back(9'h053); rq[2].push_back(9'h154);
        run_phase("t3", 3, 3, 5, 0, 0);

        // Burst cap: 20 bytes from req3 with req0 waiting.
        for (int b = 0; b < 20; b++) rq[3].push_back({b == 19, 8'(8'h60 + b)});
        rq[0].push_back(9'h0A0); rq[0].push_back(9'h1A1);
        run_phase("t4", 0, -1, -1, 0, 0);

        // Move rr_ptr away from 0, then reset mid-packet.
        rq[1].push_back(9'h177);
        run_phase("t5_pre", 0, -1, -1, 0, 0);
        rq[2].push_back(9'h081); rq[2].push_back(9'h082);
        rq[2].push_back(9'h083); rq[2].push_back(9'h184);
        run_phase("t5", -1, -1, -1, 0, 2);
        #1 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        foreach (rq[i]) rq[i].delete();
        exq.delete();
        m_ptr = 0;
        drive(0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // All requesters, single-byte packets: order restarts at 0.
        for (int i = 0; i < NR; i++) begin
            rq[i].push_back({1'b1, 8'(8'hC0 + i)});
            rq[i].push_back({1'b1, 8'(8'hD0 + i)});
        end
        run_phase("t6", 0, -1, -1, 0, 0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NR; i++) begin
                int np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) begin
                    int len = ($urandom_range(0, 5) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 5);
                    for (int b = 0; b < len; b++) rq[i].push_back({b == len - 1, 8'($urandom)});
                end
            end
            run_phase("rand", (r % 2 == 0) ? 0 : -1, -1, -1, 1'(r % 2), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
